// File: rtl/tqvp_dlmiles_i2c_bitseq.sv
// I2C master bit sequencer: turns START/STOP/WRITE/READ primitives into SCL/SDA open-drain
// enables, paced by the phase timer's tick strobes; handles stretching, arbitration loss and timeout.
module tqvp_dlmiles_i2c_bitseq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic       cmd_bit_i,
    output logic       rsp_valid_o,
    output logic       rsp_bit_o,
    output logic       rsp_arblost_o,
    output logic       rsp_timeout_o,
    output logic       timer_clear_o,
    output logic       timer_run_o,
    input  logic       stb_tick_edgewait_i,
    input  logic       stb_tick_prewait_i,
    input  logic       stb_tick_sclhigh_i,
    input  logic       stb_tick_scllow_i,
    input  logic       stb_tick_overflow_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic       busy_o
);

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HOLD,
        ST_S_SU, ST_S_HD,
        ST_R_LO, ST_R_STR,
        ST_B_LO, ST_B_STR, ST_B_HI,
        ST_P_LO, ST_P_STR, ST_P_SU, ST_P_BUF
    } state_t;

    state_t     state_q, state_d;
    logic       first_q, first_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic [1:0] op_q, op_d;
    logic       bit_q, bit_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_bit_q, rsp_bit_d;
    logic       rsp_arblost_q, rsp_arblost_d;
    logic       rsp_timeout_q, rsp_timeout_d;

    logic idle_or_hold, accept;
    logic tk_ew, tk_pw, tk_sh, tk_sl, tk_ov, scl_up;

    assign idle_or_hold = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign cmd_ready_o  = idle_or_hold & ~rsp_valid_q;
    assign accept       = cmd_valid_i & cmd_ready_o;

    // The first cycle of every phase clears the timer, so anything seen then is stale.
    assign tk_ew  = stb_tick_edgewait_i & ~first_q;
    assign tk_pw  = stb_tick_prewait_i  & ~first_q;
    assign tk_sh  = stb_tick_sclhigh_i  & ~first_q;
    assign tk_sl  = stb_tick_scllow_i   & ~first_q;
    assign tk_ov  = stb_tick_overflow_i & ~first_q;
    assign scl_up = scl_i & ~first_q;

    always_comb begin
        state_d       = state_q;
        first_d       = 1'b0;
        scl_oe_d      = scl_oe_q;
        sda_oe_d      = sda_oe_q;
        op_d          = op_q;
        bit_d         = bit_q;
        rsp_valid_d   = 1'b0;
        rsp_bit_d     = 1'b0;
        rsp_arblost_d = 1'b0;
        rsp_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                op_d  = cmd_op_i;
                bit_d = cmd_bit_i;
                if (cmd_op_i == OP_START) begin
                    state_d = ST_S_SU;
                    first_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            ST_HOLD: if (accept) begin
                op_d    = cmd_op_i;
                bit_d   = cmd_bit_i;
                first_d = 1'b1;
                case (cmd_op_i)
                    OP_START: begin state_d = ST_R_LO; sda_oe_d = 1'b0; end
                    OP_STOP:  begin state_d = ST_P_LO; sda_oe_d = 1'b1; end
                    default:  state_d = ST_B_LO;
                endcase
            end
            ST_S_SU: if (tk_pw) begin
                state_d  = ST_S_HD;
                first_d  = 1'b1;
                sda_oe_d = 1'b1;
            end
            ST_S_HD: if (tk_pw) begin
                state_d     = ST_HOLD;
                scl_oe_d    = 1'b1;
                rsp_valid_d = 1'b1;
            end
            ST_R_LO, ST_B_LO, ST_P_LO: begin
                if (state_q == ST_B_LO && tk_ew)
                    sda_oe_d = (op_q == OP_WRITE) ? ~bit_q : 1'b0;
                if (tk_sl) begin
                    first_d  = 1'b1;
                    scl_oe_d = 1'b0;
                    if (state_q == ST_R_LO)      state_d = ST_R_STR;
                    else if (state_q == ST_B_LO) state_d = ST_B_STR;
                    else                         state_d = ST_P_STR;
                end
            end
            ST_R_STR, ST_B_STR, ST_P_STR: begin
                if (tk_ov) begin
                    state_d       = ST_IDLE;
                    scl_oe_d      = 1'b0;
                    sda_oe_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (scl_up) begin
                    first_d = 1'b1;
                    if (state_q == ST_R_STR)      state_d = ST_S_SU;
                    else if (state_q == ST_B_STR) state_d = ST_B_HI;
                    else                          state_d = ST_P_SU;
                end
            end
            ST_B_HI: if (tk_sh) begin
                rsp_valid_d = 1'b1;
                rsp_bit_d   = sda_i;
                // Lost arbitration: another master pulled SDA low while we released it.
                if (op_q == OP_WRITE && bit_q && !sda_i) begin
                    state_d       = ST_IDLE;
                    scl_oe_d      = 1'b0;
                    sda_oe_d      = 1'b0;
                    rsp_arblost_d = 1'b1;
                end else begin
                    state_d  = ST_HOLD;
                    scl_oe_d = 1'b1;
                end
            end
            ST_P_SU: if (tk_pw) begin
                state_d  = ST_P_BUF;
                first_d  = 1'b1;
                sda_oe_d = 1'b0;
            end
            ST_P_BUF: if (tk_pw) begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            first_q       <= 1'b0;
            scl_oe_q      <= 1'b0;
            sda_oe_q      <= 1'b0;
            op_q          <= 2'b00;
            bit_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_bit_q     <= 1'b0;
            rsp_arblost_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            first_q       <= first_d;
            scl_oe_q      <= scl_oe_d;
            sda_oe_q      <= sda_oe_d;
            op_q          <= op_d;
            bit_q         <= bit_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_bit_q     <= rsp_bit_d;
            rsp_arblost_q <= rsp_arblost_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign busy_o        = ~idle_or_hold;
    assign timer_clear_o = first_q;
    assign timer_run_o   = busy_o & ~first_q;
    assign scl_oe_o      = scl_oe_q;
    assign sda_oe_o      = sda_oe_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_bit_o     = rsp_bit_q;
    assign rsp_arblost_o = rsp_arblost_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_bitseq.sv
// Bench for the I2C bit sequencer: models the phase timer and an open-drain bus with a
// scriptable slave, and scoreboards every response.
module tb_tqvp_dlmiles_i2c_bitseq;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_bit = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_bit, rsp_arblost, rsp_timeout;
    logic       timer_clear, timer_run, scl_oe, sda_oe, busy;
    logic       slv_scl_hold = 1'b0;
    logic       slv_sda_low = 1'b0;
    logic [15:0] tcnt;
    logic       tk_ew, tk_pw, tk_sh, tk_sl, tk_ov, scl_line, sda_line;

    int n_run = 0;
    int n_fail = 0;
    int rsp_cnt = 0;
    int clr_cnt = 0;
    int start_ok = 0, fall_hi = 0, rise_hi = 0, rel_lo = 0, chg_ok = 0, chg_bad = 0;
    logic in_byte = 1'b0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    // Phase timer model: 16 counts per bit period.
    always @(posedge clk) begin
        if (rst || timer_clear) tcnt <= 16'd0;
        else if (timer_run && tcnt != 16'hFFFF) tcnt <= tcnt + 16'd1;
    end
    assign tk_ew = (tcnt == 16'd2);
    assign tk_pw = (tcnt == 16'd6);
    assign tk_sh = (tcnt >= 16'd7);
    assign tk_sl = (tcnt == 16'd9);
    assign tk_ov = (tcnt >= 16'd511);
    assign scl_line = ~scl_oe & ~slv_scl_hold;
    assign sda_line = ~sda_oe & ~slv_sda_low;

    tqvp_dlmiles_i2c_bitseq dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_bit_i(cmd_bit),
        .rsp_valid_o(rsp_valid), .rsp_bit_o(rsp_bit),
        .rsp_arblost_o(rsp_arblost), .rsp_timeout_o(rsp_timeout),
        .timer_clear_o(timer_clear), .timer_run_o(timer_run),
        .stb_tick_edgewait_i(tk_ew), .stb_tick_prewait_i(tk_pw),
        .stb_tick_sclhigh_i(tk_sh), .stb_tick_scllow_i(tk_sl),
        .stb_tick_overflow_i(tk_ov),
        .scl_i(scl_line), .sda_i(sda_line),
        .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .busy_o(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor and line-edge bookkeeping, sampled mid-cycle.
    logic prev_sda_oe = 1'b0, prev_ew = 1'b0, prev_pw = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_sda_oe = 1'b0;
        end else begin
            if (timer_clear) clr_cnt++;
            if (rsp_valid) begin
                rsp_cnt++;
                check_eq("rdy_in_rsp", cmd_ready, 0);
                if (exp_q.size() == 0) check_eq("rsp_unexpected", 1, exp_q.size());
                else check_eq("rsp_bit_arb_tmo", {rsp_bit, rsp_arblost, rsp_timeout}, exp_q.pop_front());
            end
            if (sda_oe != prev_sda_oe) begin
                if (in_byte) begin
                    if (prev_ew) chg_ok++;
                    else chg_bad++;
                end
                if (sda_oe && scl_line) begin
                    fall_hi++;
                    if (prev_pw) start_ok++;
                end
                if (!sda_oe && scl_line) rise_hi++;
                if (!sda_oe && scl_oe) rel_lo++;
            end
            prev_sda_oe = sda_oe;
        end
        prev_ew = tk_ew;
        prev_pw = tk_pw;
    end

    task automatic issue(input logic [1:0] op, input logic b, input logic [2:0] exp);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check_eq("issue_ready", cmd_ready, 1);
        exp_q.push_back(exp);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_bit   = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_bit   = 1'($urandom);
    endtask

    task automatic wait_rsp(input int budget);
        int n0 = rsp_cnt;
        logic ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (rsp_cnt != n0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        check_eq("rsp_wait", ok, 1);
    endtask

    task automatic send(input logic [1:0] op, input logic b, input logic [2:0] exp);
        issue(op, b, exp);
        wait_rsp(1000);
    endtask

    initial begin
        logic [7:0] byte_v;
        int c0, f0, r0, l0, n0, hits;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_oe", {scl_oe, sda_oe}, 0);
        check_eq("rst_busy_clr_run", {busy, timer_clear, timer_run}, 0);
        check_eq("rst_rsp", {rsp_valid, rsp_bit, rsp_arblost, rsp_timeout}, 0);
        rst = 1'b0;

        // Data commands and STOP with no bus ownership answer at once.
        send(OP_WRITE, 1'b1, 3'b000);
        check_eq("idle_wr_lines", {scl_oe, sda_oe, busy}, 0);
        send(OP_STOP, 1'b0, 3'b000);
        check_eq("idle_stop_ready", cmd_ready, 1);

        // START from IDLE
        c0 = clr_cnt;
        send(OP_START, 1'b0, 3'b000);
        check_eq("start_clr_pulses", clr_cnt - c0, 2);
        check_eq("start_sda_after_pw", start_ok, 1);
        check_eq("start_hold_lines", {scl_oe, sda_oe}, 2'b11);
        check_eq("start_hold_idle", {busy, cmd_ready}, 2'b01);

        // 0x5A MSB first, then READ with ACK from the slave
        byte_v = 8'h5A;
        in_byte = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send(OP_WRITE, byte_v[i], {byte_v[i], 2'b00});
            check_eq("wr_sda_oe", sda_oe, {31'd0, ~byte_v[i]});
            check_eq("wr_scl_held", scl_oe, 1);
        end
        slv_sda_low = 1'b1;
        send(OP_READ, 1'b1, 3'b000);
        slv_sda_low = 1'b0;
        in_byte = 1'b0;
        check_eq("rd_sda_released", sda_oe, 0);
        check_eq("byte_chg_at_ew", chg_ok, 7);
        check_eq("byte_chg_elsewhere", chg_bad, 0);

        // Clock stretch of 20 bit periods, no timeout
        slv_scl_hold = 1'b1;
        n0 = rsp_cnt;
        issue(OP_WRITE, 1'b1, 3'b100);
        repeat (320) @(posedge clk);
        #1;
        check_eq("str_no_rsp", rsp_cnt - n0, 0);
        check_eq("str_busy_run", {busy, timer_run, scl_oe}, 3'b110);
        slv_scl_hold = 1'b0;
        wait_rsp(100);
        check_eq("str_back_hold", {scl_oe, busy}, 2'b10);

        // Stretch beyond overflow
        slv_scl_hold = 1'b1;
        send(OP_WRITE, 1'b0, 3'b001);
        check_eq("tmo_lines", {scl_oe, sda_oe}, 0);
        check_eq("tmo_idle", {busy, cmd_ready}, 2'b01);
        slv_scl_hold = 1'b0;

        // Arbitration loss
        send(OP_START, 1'b0, 3'b000);
        slv_sda_low = 1'b1;
        send(OP_WRITE, 1'b1, 3'b010);
        check_eq("arb_lines", {scl_oe, sda_oe}, 0);
        check_eq("arb_idle", {busy, cmd_ready}, 2'b01);
        slv_sda_low = 1'b0;

        // Repeated START then STOP
        send(OP_START, 1'b0, 3'b000);
        send(OP_WRITE, 1'b0, 3'b000);
        f0 = fall_hi; r0 = rise_hi; l0 = rel_lo;
        send(OP_START, 1'b0, 3'b000);
        check_eq("rs_sda_rel_scl_low", rel_lo - l0, 1);
        check_eq("rs_sda_fall_scl_high", fall_hi - f0, 1);
        send(OP_STOP, 1'b0, 3'b000);
        check_eq("stop_sda_rise_scl_high", rise_hi - r0, 1);
        check_eq("stop_idle", {busy, cmd_ready, scl_oe, sda_oe}, 4'b0100);

        // Reset in B_HI: second timer clear with SCL released during a WRITE
        send(OP_START, 1'b0, 3'b000);
        issue(OP_WRITE, 1'b1, 3'b100);
        hits = 0;
        for (int i = 0; i < 200 && hits < 2; i++) begin
            @(negedge clk);
            if (timer_clear && !scl_oe && busy) hits++;
        end
        check_eq("bhi_reached", hits, 2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_lines", {scl_oe, sda_oe}, 0);
        check_eq("rst_mid_busy_ready", {busy, cmd_ready}, 2'b01);
        exp_q.delete();
        rst = 1'b0;

        send(OP_WRITE, 1'b0, 3'b000);
        check_eq("post_rst_idle", {busy, scl_oe, sda_oe}, 0);
        check_eq("q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tqvp_dlmiles_i2c_bitseq.md
# tqvp_dlmiles_i2c_bitseq

I2C master bit sequencer sitting directly downstream of the I2C phase timer. It accepts one bus primitive at a time (START, STOP, WRITE bit, READ bit) from the byte/register layer. It sequences SCL/SDA open-drain enables using the timer's tick strobes, and drives the timer's run and clear controls. It handles repeated START, SCL clock stretching, arbitration-loss detection and a stretch timeout.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_op_i` in 2: command op. 00 START, 01 STOP, 10 WRITE, 11 READ.
- `cmd_bit_i` in 1: data bit for WRITE. Ignored for other ops.
- `rsp_valid_o` out 1: one-cycle pulse when a command completes.
- `rsp_bit_o` out 1: SDA sampled at the SCL-high tick (WRITE/READ). 0 for START/STOP.
- `rsp_arblost_o` out 1: WRITE of 1 sampled as 0. Qualified by `rsp_valid_o`.
- `rsp_timeout_o` out 1: stretch timeout. Qualified by `rsp_valid_o`.
- `timer_clear_o` out 1: one-cycle pulse; resets the timer (count and latched ticks).
- `timer_run_o` out 1: timer count enable.
- `stb_tick_edgewait_i` in 1: 2/16 tick.
- `stb_tick_prewait_i` in 1: 6/16 tick.
- `stb_tick_sclhigh_i` in 1: 7/16 tick, level-latched until clear.
- `stb_tick_scllow_i` in 1: 9/16 tick.
- `stb_tick_overflow_i` in 1: 511/16 tick, latched.
- `scl_i`, `sda_i` in 1: bus levels, already synchronised.
- `scl_oe_o`, `sda_oe_o` out 1: 1 = drive line low, 0 = release.
- `busy_o` out 1: not in IDLE/HOLD.

## Operation
- States:
  - IDLE: bus free, both lines released.
  - HOLD: SCL held low, owning the bus, awaiting the next command.
  - Phase states, per op below.
- Every phase state's first cycle asserts `timer_clear_o`, deasserts `timer_run_o`, and ignores all tick inputs. From the second cycle onward `timer_run_o`=1 until the phase exits.
- `cmd_ready_o`=1 only in IDLE and HOLD.
- Illegal commands:
  - In IDLE, WRITE/READ/STOP complete immediately with `rsp_valid_o`, no bus activity.
  - In HOLD, a repeated START is legal.
- START from IDLE:
  - S_SU: both released; wait prewait.
  - S_HD: `sda_oe`=1; wait prewait.
  - Then `scl_oe`=1, respond, go to HOLD.
- START from HOLD (repeated START):
  - R_LO: SCL low, release SDA; wait scllow.
  - R_STR: release SCL; wait `scl_i`=1.
  - Then S_SU, S_HD as above.
- WRITE/READ:
  - B_LO: SCL low; at edgewait set `sda_oe` = ~`cmd_bit_i` (READ: 0); wait scllow.
  - B_STR: release SCL; wait `scl_i`=1.
  - B_HI: wait sclhigh level; capture `sda_i`.
  - Then `scl_oe`=1 (SDA unchanged), respond, go to HOLD.
- Arbitration: on WRITE with `cmd_bit_i`=1 and captured 0:
  - `rsp_arblost_o`=1.
  - Release both lines immediately.
  - Go to IDLE.
- STOP from HOLD:
  - P_LO: SCL low, `sda_oe`=1; wait scllow.
  - P_STR: release SCL; wait `scl_i`=1.
  - P_SU: wait prewait; release SDA.
  - P_BUF: wait prewait.
  - Then respond, go to IDLE.
- Stretch timeout: in any *_STR state, `stb_tick_overflow_i`=1 (after the clear cycle) causes:
  - release both lines;
  - `rsp_valid_o`=1 with `rsp_timeout_o`=1;
  - go to IDLE.
- `cmd_op_i`/`cmd_bit_i` are latched at accept; the master may change them afterwards.

## Timing
- Reset values:
  - `cmd_ready_o`=1.
  - `scl_oe_o`=0, `sda_oe_o`=0.
  - `rsp_*`=0, `timer_clear_o`=0, `timer_run_o`=0, `busy_o`=0.
  - State IDLE.
- Reset mid-operation: the next cycle shows reset values; lines are released at once.
- Accept to first phase state: 1 cycle. Accept to `timer_clear_o`: same cycle as phase entry.
- Phase exit occurs the cycle after the qualifying tick is sampled. `rsp_valid_o` is asserted in that exit cycle.
- `cmd_ready_o` returns the cycle after `rsp_valid_o`.
- Sampling: `sda_i` is sampled in the cycle `stb_tick_sclhigh_i` is first seen high in B_HI.
- Lines change only on state transitions or the edgewait tick. SDA never changes while SCL is released, except the START/STOP edges defined above.
- Simultaneous events: tick inputs coinciding with `timer_clear_o` are discarded. Overflow in a non-STR state is ignored.

## Test plan
- Reset, then START from IDLE:
  - `timer_clear_o` pulses twice.
  - `sda_oe` rises 1 cycle after the first prewait tick.
  - `scl_oe` rises after the second prewait tick.
  - `rsp_valid_o`=1, `rsp_bit_o`=0; state HOLD.
- WRITE 0x5A as 8 bits plus READ (ACK), with slave pulling SDA low on bit 9:
  - `sda_oe` pattern is ~bits, each change at edgewait.
  - `rsp_bit_o` returns 0,1,0,1,1,0,1,0 then 0.
- Slave holds `scl_i`=0 for 20 ticks in B_STR:
  - B_HI is entered only after `scl_i`=1.
  - No timeout is flagged.
  - Holding beyond the overflow tick instead gives `rsp_timeout_o`=1, both OE=0, state IDLE.
- WRITE 1 with `sda_i` forced 0: `rsp_arblost_o`=1, `rsp_bit_o`=0, both OE=0, `cmd_ready_o`=1, IDLE.
- Repeated START from HOLD, then STOP: SDA is released while SCL is low, the SDA fall occurs with SCL high, and the STOP SDA rise occurs with SCL high; final state IDLE.
- Assert `rst` during B_HI: the next cycle shows all OE=0, `busy_o`=0, `cmd_ready_o`=1.
